// File: rtl/dnn_pkg.sv
// Shared types and sizing for the shared-MAC DNN sequencer.
// Optional request queuing is enabled by defining DNN_SEQ_PEND_EN (see dnn_seq_ctrl).
package dnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_MAC  = 2'd2,
        ST_WB   = 2'd3
    } dnn_state_e;

    localparam int NUM_IN    = 4;
    localparam int NUM_HID   = 4;
    localparam int NUM_OUT   = 2;
    localparam int W_ADDR_W  = 5;

    // Output-layer weights sit directly after the input->hidden block.
    localparam int HID_WBASE = NUM_IN * NUM_HID;

    // Cycles from the first CLR to the last WB inclusive.
    localparam int SEQ_LEN   = NUM_HID * (NUM_IN + 2) + NUM_OUT * (NUM_HID + 2);

endpackage

// File: rtl/dnn_seq_ctrl_if.sv
// Sequencer <-> datapath control bundle. master = sequencer, slave = datapath.
interface dnn_seq_ctrl_if #(
    parameter int W_ADDR_W = 5
);
    logic                in_ready;
    logic                in_capture;
    logic                busy;
    logic                mac_clr;
    logic                mac_en;
    logic                layer;
    logic [1:0]          op_sel;
    logic [W_ADDR_W-1:0] w_addr;
    logic                h_wr_en;
    logic                o_wr_en;
    logic [1:0]          nrn_idx;
    logic                out0_ready;
    logic                out1_ready;

    modport master (
        input  in_ready,
        output in_capture, busy, mac_clr, mac_en, layer, op_sel, w_addr,
               h_wr_en, o_wr_en, nrn_idx, out0_ready, out1_ready
    );

    modport slave (
        output in_ready,
        input  in_capture, busy, mac_clr, mac_en, layer, op_sel, w_addr,
               h_wr_en, o_wr_en, nrn_idx, out0_ready, out1_ready
    );
endinterface

// File: rtl/dnn_seq_addr_gen.sv
// Weight-bank address from (layer, operand index, neuron index).
// Hidden: cnt*NUM_HID + nrn.  Output: WBASE + cnt*NUM_OUT + nrn.
module dnn_seq_addr_gen
    import dnn_pkg::*;
#(
    parameter int NUM_HID  = dnn_pkg::NUM_HID,
    parameter int NUM_OUT  = dnn_pkg::NUM_OUT,
    parameter int WBASE    = dnn_pkg::HID_WBASE,
    parameter int W_ADDR_W = dnn_pkg::W_ADDR_W
) (
    input  logic                layer,
    input  logic [1:0]          cnt,
    input  logic [1:0]          nrn,
    output logic [W_ADDR_W-1:0] w_addr
);

    logic [W_ADDR_W-1:0] cnt_w;
    logic [W_ADDR_W-1:0] nrn_w;

    assign cnt_w = W_ADDR_W'(cnt);
    assign nrn_w = W_ADDR_W'(nrn);

    // Constant multipliers only; these reduce to shifts/adds.
    always_comb begin
        if (layer)
            w_addr = W_ADDR_W'(WBASE) + cnt_w * W_ADDR_W'(NUM_OUT) + nrn_w;
        else
            w_addr = cnt_w * W_ADDR_W'(NUM_HID) + nrn_w;
    end

endmodule

// File: rtl/dnn_seq_ctrl.sv
// Shared-MAC sequencer for the 4/4/2 DNN: hidden pass then output pass.
// Define DNN_SEQ_PEND_EN to queue one start request that arrives while busy.
//
// state | meaning
// IDLE  | waiting for in_ready (or a pending request); in_capture pulses here
// CLR   | clear accumulator for neuron nrn of layer
// MAC   | accumulate operand[cnt] * weight, cnt = 0..fan_in-1
// WB    | write accumulator to hidden/output register nrn, advance neuron/layer
module dnn_seq_ctrl
    import dnn_pkg::*;
#(
    parameter int NUM_IN   = dnn_pkg::NUM_IN,
    parameter int NUM_HID  = dnn_pkg::NUM_HID,
    parameter int NUM_OUT  = dnn_pkg::NUM_OUT,
    parameter int W_ADDR_W = dnn_pkg::W_ADDR_W
) (
    input  logic           clk,
    input  logic           rst_n,
    dnn_seq_ctrl_if.master bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CLR  = ST_CLR;
    localparam logic [1:0] S_MAC  = ST_MAC;
    localparam logic [1:0] S_WB   = ST_WB;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q,   cnt_d;
    logic [1:0] nrn_q,   nrn_d;
    logic       layer_q, layer_d;
    logic       out0_q,  out0_d;
    logic       out1_q,  out1_d;
    logic       capture;
    logic [1:0] cnt_last;
    logic [1:0] nrn_last;
    logic [W_ADDR_W-1:0] w_addr;

`ifdef DNN_SEQ_PEND_EN
    logic pend_q, pend_d;

    assign capture = (state_q == S_IDLE) && (bus.in_ready || pend_q);

    // One-deep request memory; repeated requests while busy merge.
    always_comb begin
        pend_d = pend_q;
        if (capture)
            pend_d = 1'b0;
        else if ((state_q != S_IDLE) && bus.in_ready)
            pend_d = 1'b1;
    end

    // Pend flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= pend_d;
    end
`else
    assign capture = (state_q == S_IDLE) && bus.in_ready;
`endif

    assign cnt_last = layer_q ? 2'(NUM_HID - 1) : 2'(NUM_IN - 1);
    assign nrn_last = layer_q ? 2'(NUM_OUT - 1) : 2'(NUM_HID - 1);

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nrn_d   = nrn_q;
        layer_d = layer_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_CLR;
                    cnt_d   = 2'd0;
                    nrn_d   = 2'd0;
                    layer_d = 1'b0;
                    out0_d  = 1'b0;
                    out1_d  = 1'b0;
                end
            end
            S_CLR: begin
                state_d = S_MAC;
                cnt_d   = 2'd0;
            end
            S_MAC: begin
                if (cnt_q == cnt_last) state_d = S_WB;
                else                   cnt_d   = cnt_q + 2'd1;
            end
            default: begin
                if (layer_q && (nrn_q == 2'd0)) out0_d = 1'b1;
                if (layer_q && (nrn_q == 2'd1)) out1_d = 1'b1;
                if (nrn_q != nrn_last) begin
                    nrn_d   = nrn_q + 2'd1;
                    state_d = S_CLR;
                end else if (!layer_q) begin
                    layer_d = 1'b1;
                    nrn_d   = 2'd0;
                    state_d = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Sequencer registers; reset abandons any partial sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            nrn_q   <= 2'd0;
            layer_q <= 1'b0;
            out0_q  <= 1'b0;
            out1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nrn_q   <= nrn_d;
            layer_q <= layer_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
        end
    end

    dnn_seq_addr_gen #(
        .NUM_HID  (NUM_HID),
        .NUM_OUT  (NUM_OUT),
        .WBASE    (NUM_IN * NUM_HID),
        .W_ADDR_W (W_ADDR_W)
    ) u_addr_gen (
        .layer  (layer_q),
        .cnt    (cnt_q),
        .nrn    (nrn_q),
        .w_addr (w_addr)
    );

    // Strobes are masked while rst_n is low so a reset cycle never writes.
    assign bus.in_capture = rst_n && capture;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.mac_clr    = rst_n && (state_q == S_CLR);
    assign bus.mac_en     = rst_n && (state_q == S_MAC);
    assign bus.h_wr_en    = rst_n && (state_q == S_WB) && !layer_q;
    assign bus.o_wr_en    = rst_n && (state_q == S_WB) && layer_q;
    assign bus.layer      = layer_q;
    assign bus.op_sel     = cnt_q;
    assign bus.w_addr     = w_addr;
    assign bus.nrn_idx    = nrn_q;
    assign bus.out0_ready = out0_q;
    assign bus.out1_ready = out1_q;

endmodule

// File: tb/tb_dnn_seq_ctrl.sv
// Directed bench for dnn_seq_ctrl; pend scenario runs when DNN_SEQ_PEND_EN is defined.
module tb_dnn_seq_ctrl;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // per-cycle stimulus and trace storage
    logic       req_vec [0:99];
    logic       rst_vec [0:99];
    logic [7:0] tr_ctrl [0:99];
    logic       tr_lay  [0:99];
    logic [1:0] tr_op   [0:99];
    logic [4:0] tr_wa   [0:99];
    logic [1:0] tr_nrn  [0:99];

    dnn_seq_ctrl_if #(.W_ADDR_W(5)) bus ();

    dnn_seq_ctrl #(
        .NUM_IN   (4),
        .NUM_HID  (4),
        .NUM_OUT  (2),
        .W_ADDR_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {in_capture, mac_clr, mac_en, h_wr_en, o_wr_en, busy, out0_ready, out1_ready}
    // at cycle c of a sequence started at c=0; prev = ready flags before the start.
    function automatic logic [7:0] exp_ctrl(input int c, input logic prev);
        logic cap, clr, en, h, o, bsy, r0, r1;
        int n, ph;
        cap = (c == 0);
        clr = 1'b0; en = 1'b0; h = 1'b0; o = 1'b0; bsy = 1'b0;
        if (c >= 1 && c <= 36) begin
            n   = (c - 1) / 6;
            ph  = (c - 1) % 6;
            bsy = 1'b1;
            clr = (ph == 0);
            en  = (ph >= 1 && ph <= 4);
            h   = (ph == 5) && (n < 4);
            o   = (ph == 5) && (n >= 4);
        end
        r0 = (c == 0) ? prev : (c >= 31);
        r1 = (c == 0) ? prev : (c >= 37);
        return {cap, clr, en, h, o, bsy, r0, r1};
    endfunction

    // Expected weight address during a MAC cycle of neuron n, operand i.
    function automatic int exp_addr(input int n, input int i);
        if (n < 4) return i * 4 + n;
        return 16 + i * 2 + (n - 4);
    endfunction

    task automatic clear_vecs();
        for (int i = 0; i < 100; i++) begin
            req_vec[i] = 1'b0;
            rst_vec[i] = 1'b0;
        end
    endtask

    // Called just after a posedge; drives cycle c inputs, samples at negedge.
    task automatic run_seq(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bus.in_ready = req_vec[c];
            rst_n        = !rst_vec[c];
            @(negedge clk);
            tr_ctrl[c] = {bus.in_capture, bus.mac_clr, bus.mac_en, bus.h_wr_en,
                          bus.o_wr_en, bus.busy, bus.out0_ready, bus.out1_ready};
            tr_lay[c]  = bus.layer;
            tr_op[c]   = bus.op_sel;
            tr_wa[c]   = bus.w_addr;
            tr_nrn[c]  = bus.nrn_idx;
            @(posedge clk);
            #1;
        end
        bus.in_ready = 1'b0;
        rst_n        = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] obs;
        rst_n        = 1'b0;
        bus.in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        obs = {bus.in_capture, bus.mac_clr, bus.mac_en, bus.h_wr_en, bus.o_wr_en,
               bus.busy, bus.out0_ready, bus.out1_ready, bus.layer, bus.op_sel,
               bus.w_addr, bus.nrn_idx, 4'd0};
        checks++;
        if (obs !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got %b exp all zero", obs);
        end
        bus.in_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_capture !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b cap=%b exp 0 0", bus.busy, bus.in_capture);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int w0 [4];
        int w5 [4];
        int n, ph;
        w0 = '{0, 4, 8, 12};
        w5 = '{17, 19, 21, 23};
        clear_vecs();
        req_vec[0] = 1'b1;
        run_seq(40);
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tr_ctrl[c] !== exp_ctrl(c, 1'b0)) begin
                failures++;
                $display("FAIL nominal_ctrl cycle %0d got %b exp %b", c, tr_ctrl[c], exp_ctrl(c, 1'b0));
            end
        end
        for (int c = 1; c <= 36; c++) begin
            n  = (c - 1) / 6;
            ph = (c - 1) % 6;
            if (ph >= 1 && ph <= 4) begin
                checks++;
                if ({tr_lay[c], tr_op[c], tr_wa[c]} !== {n >= 4, 2'(ph - 1), 5'(exp_addr(n, ph - 1))}) begin
                    failures++;
                    $display("FAIL nominal_mac cycle %0d got lay=%b op=%0d wa=%0d exp lay=%b op=%0d wa=%0d",
                             c, tr_lay[c], tr_op[c], tr_wa[c], n >= 4, ph - 1, exp_addr(n, ph - 1));
                end
            end else if (ph == 5) begin
                checks++;
                if (tr_nrn[c] !== 2'(n % 4)) begin
                    failures++;
                    $display("FAIL nominal_wb_nrn cycle %0d got %0d exp %0d", c, tr_nrn[c], n % 4);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_wa[2 + i] !== 5'(w0[i])) begin
                failures++;
                $display("FAIL w_addr_h0 step %0d got %0d exp %0d", i, tr_wa[2 + i], w0[i]);
            end
            checks++;
            if (tr_wa[32 + i] !== 5'(w5[i]) || tr_op[32 + i] !== 2'(i) || tr_lay[32 + i] !== 1'b1) begin
                failures++;
                $display("FAIL w_addr_o1 step %0d got wa=%0d op=%0d lay=%b exp wa=%0d op=%0d lay=1",
                         i, tr_wa[32 + i], tr_op[32 + i], tr_lay[32 + i], w5[i], i);
            end
        end
        checks++;
        if (tr_ctrl[36][3] !== 1'b1 || tr_nrn[36] !== 2'd1) begin
            failures++;
            $display("FAIL o_wr_en_k1 got o=%b nrn=%0d exp o=1 nrn=1", tr_ctrl[36][3], tr_nrn[36]);
        end
    endtask

`ifndef DNN_SEQ_PEND_EN
    task automatic test_hold_in_ready();
        clear_vecs();
        req_vec[0] = 1'b1;
        for (int c = 5; c <= 20; c++) req_vec[c] = 1'b1;
        run_seq(45);
        for (int c = 0; c < 45; c++) begin
            checks++;
            if (tr_ctrl[c] !== exp_ctrl(c, 1'b1)) begin
                failures++;
                $display("FAIL hold_ctrl cycle %0d got %b exp %b", c, tr_ctrl[c], exp_ctrl(c, 1'b1));
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [22:0] obs;
        clear_vecs();
        req_vec[0]  = 1'b1;
        rst_vec[15] = 1'b1;
        run_seq(25);
        for (int c = 0; c < 15; c++) begin
            checks++;
            if (tr_ctrl[c] !== exp_ctrl(c, 1'b1)) begin
                failures++;
                $display("FAIL rstmid_pre cycle %0d got %b exp %b", c, tr_ctrl[c], exp_ctrl(c, 1'b1));
            end
        end
        for (int c = 16; c < 25; c++) begin
            obs = {tr_ctrl[c], tr_lay[c], tr_op[c], tr_wa[c], tr_nrn[c], 5'd0};
            checks++;
            if (obs !== 23'd0) begin
                failures++;
                $display("FAIL rstmid_post cycle %0d got %b exp all zero", c, obs);
            end
        end
        clear_vecs();
        req_vec[0] = 1'b1;
        run_seq(40);
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (tr_ctrl[c] !== exp_ctrl(c, 1'b0)) begin
                failures++;
                $display("FAIL rstmid_restart cycle %0d got %b exp %b", c, tr_ctrl[c], exp_ctrl(c, 1'b0));
            end
        end
        checks++;
        if (tr_wa[2] !== 5'd0 || tr_wa[3] !== 5'd4 || tr_lay[2] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_restart_addr got %0d,%0d lay=%b exp 0,4 lay=0", tr_wa[2], tr_wa[3], tr_lay[2]);
        end
    endtask

    // in_ready at 0 and 37 (back-to-back) or at 0 and 10 (pending request).
    task automatic test_two_runs(input int second_req, input string tag);
        logic [7:0] e;
        clear_vecs();
        req_vec[0]          = 1'b1;
        req_vec[second_req] = 1'b1;
        run_seq(80);
        for (int c = 0; c < 80; c++) begin
            e = (c < 37) ? exp_ctrl(c, 1'b1) : exp_ctrl(c - 37, 1'b1);
            checks++;
            if (tr_ctrl[c] !== e) begin
                failures++;
                $display("FAIL %s_ctrl cycle %0d got %b exp %b", tag, c, tr_ctrl[c], e);
            end
        end
        checks++;
        if (tr_ctrl[37][7] !== 1'b1 || tr_ctrl[38][1:0] !== 2'b00 || tr_ctrl[74][0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_edges got cap37=%b rdy38=%b r1_74=%b exp 1 00 1",
                     tag, tr_ctrl[37][7], tr_ctrl[38][1:0], tr_ctrl[74][0]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_ready = 1'b0;
        test_reset();
        test_nominal();
`ifndef DNN_SEQ_PEND_EN
        test_hold_in_ready();
`endif
        test_two_runs(37, "back_to_back");
        test_reset_mid();
`ifdef DNN_SEQ_PEND_EN
        test_two_runs(10, "pend");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
